// File: rtl/ipf_feeder_if.sv
// rtl/ipf_feeder_if.sv - row SRAM and IPF input-side signal bundle for ipf_feeder
interface ipf_feeder_if #(
  parameter int Addr_Width = 16
) ();
  logic                  mem_rd;
  logic [Addr_Width-1:0] mem_addr;
  logic [63:0]           mem_rdata;
  logic [71:0]           w_data;
  logic                  w_valid;
  logic [63:0]           i_data;
  logic                  i_valid;
  logic [1:0]            ctrl;
  logic                  ipf_finish;

  modport master (
    output mem_rd, mem_addr, w_data, w_valid, i_data, i_valid, ctrl,
    input  mem_rdata, ipf_finish
  );

  modport slave (
    input  mem_rd, mem_addr, w_data, w_valid, i_data, i_valid, ctrl,
    output mem_rdata, ipf_finish
  );
endinterface

// File: rtl/ipf_feeder.sv
// rtl/ipf_feeder.sv - sequences weight load, row preload, compute windows and job end into one IPF
module ipf_feeder #(
  parameter int Addr_Width  = 16,
  parameter int COMP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [Addr_Width-1:0] base_addr_i,
  input  logic [15:0]           num_rows_i,
  input  logic [71:0]           w_in_i,
  ipf_feeder_if.master          bus,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CW = (COMP_CYCLES > 1) ? $clog2(COMP_CYCLES) : 1;
  localparam logic [1:0] CTRL_END   = 2'd0;
  localparam logic [1:0] CTRL_START = 2'd1;
  localparam logic [1:0] CTRL_HOLD  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_SEND_W, S_RD, S_CAP, S_SEND, S_RUN, S_BACK, S_END, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [Addr_Width-1:0] base_q, base_d;
  logic [15:0]           rows_q, rows_d;
  logic [15:0]           row_cnt_q, row_cnt_d, row_next;
  logic [CW-1:0]         comp_cnt_q, comp_cnt_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [Addr_Width-1:0] mem_addr_q, mem_addr_d;
  logic [71:0]           w_data_q, w_data_d;
  logic                  w_valid_q, w_valid_d;
  logic [63:0]           i_data_q, i_data_d;
  logic                  i_valid_q, i_valid_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    rows_d     = rows_q;
    row_cnt_d  = row_cnt_q;
    comp_cnt_d = comp_cnt_q;
    w_data_d   = w_data_q;
    i_data_d   = i_data_q;
    row_next   = row_cnt_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_SEND_W;
          base_d    = base_addr_i;
          rows_d    = num_rows_i;
          row_cnt_d = 16'd0;
          w_data_d  = w_in_i;
        end
      end
      S_SEND_W: state_d = (rows_q == 16'd0) ? S_END : S_RD;
      S_RD:     state_d = S_CAP;
      S_CAP: begin
        i_data_d = bus.mem_rdata;
        state_d  = S_SEND;
      end
      S_SEND: begin
        row_cnt_d = row_next;
        if (row_next < 16'd3 && row_next < rows_q) begin
          state_d = S_RD;
        end else if (row_next == rows_q && rows_q < 16'd3) begin
          state_d = S_END;
        end else begin
          state_d    = S_RUN;
          comp_cnt_d = '0;
        end
      end
      S_RUN: begin
        if (comp_cnt_q == CW'(COMP_CYCLES - 1)) state_d = S_BACK;
        else comp_cnt_d = comp_cnt_q + CW'(1);
      end
      S_BACK:   state_d = (row_cnt_q == rows_q) ? S_END : S_RD;
      S_END:    if (bus.ipf_finish) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Abort wins over every transition; a row captured in the abort cycle is dropped.
    if (abort_i && (state_q inside {S_SEND_W, S_RD, S_CAP, S_SEND, S_RUN, S_BACK})) begin
      state_d  = S_END;
      i_data_d = i_data_q;
    end

    mem_rd_d   = (state_d == S_RD);
    mem_addr_d = mem_rd_d ? base_q + Addr_Width'(row_cnt_d) : mem_addr_q;
    w_valid_d  = (state_d == S_SEND_W);
    i_valid_d  = (state_d == S_SEND);
    ctrl_d     = (state_d == S_RUN) ? CTRL_START : (state_d == S_END) ? CTRL_END : CTRL_HOLD;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      rows_q     <= '0;
      row_cnt_q  <= '0;
      comp_cnt_q <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      w_data_q   <= '0;
      w_valid_q  <= 1'b0;
      i_data_q   <= '0;
      i_valid_q  <= 1'b0;
      ctrl_q     <= CTRL_HOLD;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      rows_q     <= rows_d;
      row_cnt_q  <= row_cnt_d;
      comp_cnt_q <= comp_cnt_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      w_data_q   <= w_data_d;
      w_valid_q  <= w_valid_d;
      i_data_q   <= i_data_d;
      i_valid_q  <= i_valid_d;
      ctrl_q     <= ctrl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.w_data   = w_data_q;
  assign bus.w_valid  = w_valid_q;
  assign bus.i_data   = i_data_q;
  assign bus.i_valid  = i_valid_q;
  assign bus.ctrl     = ctrl_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
